// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared VGA raster timing definitions for the sync generator and for the
// tile-bitmap screens that consume its coordinates.
//   - DEF_* : default 640x480 @ 60 Hz timing (25 MHz pixel clock from 100 MHz)
//   - H_TOTAL / V_TOTAL : full line / frame lengths for the default timing
//   - HS_* / VS_* : sync pulse windows, start inclusive, end exclusive
//   - TILE_SHIFT : tile index = pixel coordinate >> TILE_SHIFT
//   - coord_t / tick_div_t / sync_t : shared widths and the decoded sync bundle
package vga_timing_pkg;

  localparam int COORD_W   = 10;
  localparam int DIV_W     = 4;
  localparam int MAX_TOTAL = 1 << COORD_W;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL  = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL  = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  localparam int TILE_SHIFT = 4;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [DIV_W-1:0]   tick_div_t;

  // Decoded raster flags; sync bits are active low.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen
// Divides the system clock down to the pixel rate.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   p_tick : high on the last system clock of every pixel period
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic p_tick
);

  localparam tick_div_t DIV_LAST = tick_div_t'(CLK_DIV - 1);

  tick_div_t div;

  // Free-running divider; with CLK_DIV = 1 it sits at 0, which is also the
  // last count, so p_tick stays high every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + tick_div_t'(1);
    end
  end

  // Decoded from the registered count so the tick lines up with the final
  // clock of the pixel period.
  assign p_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// VGA raster timing generator feeding the tile screens and the colour mux.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   pixel_x     : horizontal position, 0..line total-1
//   pixel_y     : vertical position, 0..frame lines-1
//   hsync       : horizontal sync, active low
//   vsync       : vertical sync, active low
//   video_on    : high while (pixel_x, pixel_y) is in the visible area
//   p_tick      : one-clk pulse on the final clk of each pixel period
//   frame_start : one-clk pulse on the first clk of (0,0) after a frame wrap
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [9:0]   pixel_x,
  output logic [9:0]   pixel_y,
  output logic         hsync,
  output logic         vsync,
  output logic         video_on,
  output logic         p_tick,
  output logic         frame_start
);

  localparam int LINE_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LINES = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST      = coord_t'(LINE_TOTAL - 1);
  localparam coord_t V_LAST      = coord_t'(FRAME_LINES - 1);
  localparam coord_t H_VISIBLE   = coord_t'(H_DISPLAY);
  localparam coord_t V_VISIBLE   = coord_t'(V_DISPLAY);
  localparam coord_t HSYNC_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HSYNC_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam coord_t VSYNC_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VSYNC_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

  // Totals above 1024 would silently alias in the 10-bit counters, and the
  // divider is only 4 bits wide.
  if (LINE_TOTAL > MAX_TOTAL || FRAME_LINES > MAX_TOTAL) begin : g_bad_total
    $error("vga_sync_gen: line or frame total exceeds 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be within 1..16");
  end
  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL ||
      HS_END > H_TOTAL || VS_END > V_TOTAL) begin : g_bad_defaults
    $error("vga_sync_gen: default timing in vga_timing_pkg is inconsistent");
  end

  coord_t h_count;
  coord_t v_count;
  coord_t h_next;
  coord_t v_next;
  logic   frame_wrap;
  sync_t  sync_next;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .p_tick (p_tick)
  );

  // Next raster position. The vertical counter only moves on the tick that
  // closes a line, and frame_wrap flags the single tick closing the frame.
  always_comb begin
    h_next     = h_count;
    v_next     = v_count;
    frame_wrap = 1'b0;
    if (p_tick) begin
      if (h_count == H_LAST) begin
        h_next = '0;
        if (v_count == V_LAST) begin
          v_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          v_next = v_count + coord_t'(1);
        end
      end else begin
        h_next = h_count + coord_t'(1);
      end
    end
  end

  // Decoding from the next-state position lets the registered flags change
  // on the same edge as the counters, so they line up with pixel_x/pixel_y.
  always_comb begin
    sync_next.hsync    = ~in_window(h_next, HSYNC_START, HSYNC_END);
    sync_next.vsync    = ~in_window(v_next, VSYNC_START, VSYNC_END);
    sync_next.video_on = (h_next < H_VISIBLE) && (v_next < V_VISIBLE);
  end

  // All externally visible raster state is registered. Reset values match
  // pixel (0,0): both syncs idle and the pixel visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count     <= '0;
      v_count     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      h_count     <= h_next;
      v_count     <= v_next;
      hsync       <= sync_next.hsync;
      vsync       <= sync_next.vsync;
      video_on    <= sync_next.video_on;
      frame_start <= frame_wrap;
    end
  end

  assign pixel_x = h_count;
  assign pixel_y = v_count;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
// Directed bench for vga_sync_gen using four instances:
//   a : default timing, CLK_DIV = 4 (reset, divider, one full line)
//   b : default timing, CLK_DIV = 1 (constant tick, 800-clk line)
//   c : tiny timing, CLK_DIV = 2 (whole frames: vsync window, frame_start)
//   d : 256x210 timing, CLK_DIV = 1 (tile lookup, asynchronous mid-frame reset)
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  logic clk;
  logic rst_a_n, rst_b_n, rst_c_n, rst_d_n;

  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c, x_d, y_d;
  logic hs_a, vs_a, vo_a, pt_a, fs_a;
  logic hs_b, vs_b, vo_b, pt_b, fs_b;
  logic hs_c, vs_c, vo_c, pt_c, fs_c;
  logic hs_d, vs_d, vo_d, pt_d, fs_d;

  int total = 0;
  int bad   = 0;

  vga_sync_gen dut_a (
    .clk(clk), .rst_n(rst_a_n), .pixel_x(x_a), .pixel_y(y_a), .hsync(hs_a),
    .vsync(vs_a), .video_on(vo_a), .p_tick(pt_a), .frame_start(fs_a)
  );

  vga_sync_gen #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .pixel_x(x_b), .pixel_y(y_b), .hsync(hs_b),
    .vsync(vs_b), .video_on(vo_b), .p_tick(pt_b), .frame_start(fs_b)
  );

  // Line = 15 pixels (HS 10..12), frame = 10 lines (VS 7..8), 300 clks/frame.
  vga_sync_gen #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_c (
    .clk(clk), .rst_n(rst_c_n), .pixel_x(x_c), .pixel_y(y_c), .hsync(hs_c),
    .vsync(vs_c), .video_on(vo_c), .p_tick(pt_c), .frame_start(fs_c)
  );

  // Line = 256 pixels (visible 0..239, HS 244..251), frame = 210 lines.
  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(240), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_DISPLAY(200), .V_FRONT(3), .V_SYNC(2), .V_BACK(5)
  ) dut_d (
    .clk(clk), .rst_n(rst_d_n), .pixel_x(x_d), .pixel_y(y_d), .hsync(hs_d),
    .vsync(vs_d), .video_on(vo_d), .p_tick(pt_d), .frame_start(fs_d)
  );

  // 100 MHz system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case some wait never completes.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic apply_stimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    int cnt;
    int low;
    int zeros;
    int vs_low;
    int fs_cnt;
    int vs_first;
    int fs_first;
    int vs_first_y;
    int vs_last_y;

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    rst_c_n = 1'b0;
    rst_d_n = 1'b0;

    // ---------------- instance a: reset and divider ----------------
    apply_stimulus(5);
    check_output("a_rst_x", x_a, 0);
    check_output("a_rst_y", y_a, 0);
    check_output("a_rst_hs", hs_a, 1);
    check_output("a_rst_vs", vs_a, 1);
    check_output("a_rst_vo", vo_a, 1);
    check_output("a_rst_fs", fs_a, 0);
    check_output("a_rst_pt", pt_a, 0);
    rst_a_n = 1'b1;

    apply_stimulus(2);
    check_output("a_pt_clk2", pt_a, 0);
    apply_stimulus(1);
    check_output("a_pt_clk3", pt_a, 1);
    check_output("a_x_before_tick", x_a, 0);
    apply_stimulus(1);
    check_output("a_x_after_tick", x_a, 1);
    check_output("a_pt_clk4", pt_a, 0);
    check_output("a_fs_after_rel", fs_a, 0);

    // ---------------- instance a: one line ----------------
    cnt = 0;
    while (vo_a !== 1'b0 && cnt < H_TOTAL * DEF_CLK_DIV) begin
      apply_stimulus(1);
      cnt++;
    end
    check_output("a_vo_fall_x", x_a, 640);
    check_output("a_hs_at_640", hs_a, 1);

    cnt = 0;
    while (hs_a !== 1'b0 && cnt < H_TOTAL * DEF_CLK_DIV) begin
      apply_stimulus(1);
      cnt++;
    end
    check_output("a_hs_fall_x", x_a, 656);

    low = 0;
    while (hs_a === 1'b0 && low < H_TOTAL * DEF_CLK_DIV) begin
      low++;
      apply_stimulus(1);
    end
    check_output("a_hs_low_clks", low, 384);
    check_output("a_hs_rise_x", x_a, 752);

    cnt = 0;
    while (x_a !== 10'd799 && cnt < H_TOTAL * DEF_CLK_DIV) begin
      apply_stimulus(1);
      cnt++;
    end
    check_output("a_x_799_y", y_a, 0);
    check_output("a_x_799_vo", vo_a, 0);
    cnt = 0;
    while (x_a === 10'd799 && cnt < 16) begin
      apply_stimulus(1);
      cnt++;
    end
    check_output("a_wrap_x", x_a, 0);
    check_output("a_wrap_y", y_a, 1);
    check_output("a_wrap_vo", vo_a, 1);
    check_output("a_wrap_fs", fs_a, 0);

    // ---------------- instance b: CLK_DIV = 1 ----------------
    check_output("b_rst_pt", pt_b, 1);
    rst_b_n = 1'b1;
    apply_stimulus(1);
    check_output("b_x_clk1", x_b, 1);
    zeros = 0;
    for (int i = 0; i < 798; i++) begin
      if (pt_b !== 1'b1) zeros++;
      apply_stimulus(1);
    end
    check_output("b_pt_never_low", zeros, 0);
    check_output("b_x_clk799", x_b, 799);
    check_output("b_y_clk799", y_b, 0);
    apply_stimulus(1);
    check_output("b_x_clk800", x_b, 0);
    check_output("b_y_clk800", y_b, 1);

    // ---------------- instance c: whole frames ----------------
    rst_c_n = 1'b1;
    vs_low = 0;
    fs_cnt = 0;
    vs_first = -1;
    fs_first = -1;
    vs_first_y = -1;
    vs_last_y = -1;
    for (int i = 1; i <= 650; i++) begin
      apply_stimulus(1);
      if (vs_c === 1'b0) begin
        vs_low++;
        vs_last_y = int'(y_c);
        if (vs_first < 0) begin
          vs_first = i;
          vs_first_y = int'(y_c);
        end
      end
      if (fs_c === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
      end
    end
    check_output("c_vs_first_clk", vs_first, 210);
    check_output("c_vs_first_line", vs_first_y, 7);
    check_output("c_vs_last_line", vs_last_y, 8);
    check_output("c_vs_low_clks", vs_low, 120);
    check_output("c_fs_first_clk", fs_first, 300);
    check_output("c_fs_count", fs_cnt, 2);

    // ---------------- instance d: tile lookup and async reset ----------------
    rst_d_n = 1'b1;
    apply_stimulus(135 * 256 + 200);
    check_output("d_tile_x", x_d, 200);
    check_output("d_tile_y", y_d, 135);
    check_output("d_tile_col", x_d[9:TILE_SHIFT], 12);
    check_output("d_tile_row", y_d[9:TILE_SHIFT], 8);
    check_output("d_tile_vo", vo_d, 1);
    apply_stimulus(45);
    check_output("d_mid_x", x_d, 245);
    check_output("d_mid_hs", hs_d, 0);

    // Drop reset between edges and look before the next edge arrives.
    #2;
    rst_d_n = 1'b0;
    #1;
    check_output("d_async_x", x_d, 0);
    check_output("d_async_y", y_d, 0);
    check_output("d_async_hs", hs_d, 1);
    check_output("d_async_vs", vs_d, 1);
    check_output("d_async_vo", vo_d, 1);
    check_output("d_async_fs", fs_d, 0);
    apply_stimulus(2);
    rst_d_n = 1'b1;
    apply_stimulus(1);
    check_output("d_restart_x", x_d, 1);
    check_output("d_restart_y", y_d, 0);
    check_output("d_restart_fs", fs_d, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
